// File: rtl/pwm_capture.sv
// Measures the period, high time and integer duty cycle of an asynchronous PWM input.
// Duty comes from a restoring divider that retires one quotient bit per clock.
module pwm_capture #(
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic [6:0]       duty_pct,
   output logic             valid,
   output logic             overflow,
   output logic             missed,
   output logic             signal_lost
);

   localparam int unsigned NumW    = CNT_W + 7;
   localparam int unsigned BitCntW = $clog2(NumW);

   localparam logic [CNT_W-1:0]   CntMax  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]   CntOne  = CNT_W'(1);
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(NumW - 1);
   localparam logic [NumW-1:0]    Hundred = NumW'(100);

   typedef enum logic [1:0] {
      StIdle,
      StMeasure,
      StDivide
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;
   logic                   s;
   logic                   rise;

   logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;

   // Divider state: num_q holds the dividend and fills with quotient bits from the LSB.
   logic [NumW-1:0]    num_q, num_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   h_q, h_d;
   logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;

   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [6:0]         duty_q, duty_d;
   logic               valid_q, valid_d;
   logic               overflow_q, overflow_d;
   logic               missed_q, missed_d;
   logic               signal_lost_q, signal_lost_d;

   logic [CNT_W:0]     trial;
   logic               trial_ge;
   logic [CNT_W-1:0]   rem_step;
   logic [NumW-1:0]    quo_step;
   logic [NumW-1:0]    num_init;
   logic [6:0]         duty_clamp;

   // ---------------------------------------------------------------------------------------------
   // Input synchronizer and rising-edge detect
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
      s      = sync_q[SYNC_STAGES-1];
      rise   = s & ~prev_q;
   end

   // ---------------------------------------------------------------------------------------------
   // One restoring-division step
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      trial    = {rem_q, num_q[NumW-1]};
      trial_ge = (trial >= {1'b0, div_q});
      // The remainder always stays below the divisor, so CNT_W bits suffice.
      rem_step = trial_ge ? (trial[CNT_W-1:0] - div_q) : trial[CNT_W-1:0];
      quo_step = {num_q[NumW-2:0], trial_ge};
      duty_clamp = (quo_step > Hundred) ? 7'd100 : quo_step[6:0];
      num_init = NumW'(hi_cnt_q) * Hundred;
   end

   // ---------------------------------------------------------------------------------------------
   // Counters, FSM and result registers
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      per_cnt_d  = per_cnt_q;
      hi_cnt_d   = hi_cnt_q;
      num_d      = num_q;
      rem_d      = rem_q;
      div_d      = div_q;
      h_d        = h_q;
      bit_cnt_d  = bit_cnt_q;
      period_d   = period_q;
      high_d     = high_q;
      duty_d     = duty_q;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      missed_d   = 1'b0;

      if (!en || (state_q == StIdle)) begin
         per_cnt_d = '0;
         hi_cnt_d  = '0;
         if (en && rise) begin
            per_cnt_d = CntOne;
            hi_cnt_d  = CntOne;
         end
      end else if (rise) begin
         per_cnt_d = CntOne;
         hi_cnt_d  = CntOne;
      end else begin
         if (per_cnt_q != CntMax) begin
            per_cnt_d = per_cnt_q + CntOne;
         end
         if (s && (hi_cnt_q != CntMax)) begin
            hi_cnt_d = hi_cnt_q + CntOne;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (en && rise) begin
               state_d = StMeasure;
            end
         end
         StMeasure: begin
            if (rise) begin
               if (per_cnt_q == CntMax) begin
                  valid_d    = 1'b1;
                  overflow_d = 1'b1;
                  period_d   = CntMax;
                  high_d     = hi_cnt_q;
                  duty_d     = 7'd0;
               end else begin
                  state_d   = StDivide;
                  num_d     = num_init;
                  rem_d     = '0;
                  div_d     = per_cnt_q;
                  h_d       = hi_cnt_q;
                  bit_cnt_d = '0;
               end
            end
         end
         StDivide: begin
            num_d     = quo_step;
            rem_d     = rem_step;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            // A period that closes while dividing is dropped; the divide carries on.
            if (rise) begin
               missed_d = 1'b1;
            end
            if (bit_cnt_q == LastBit) begin
               state_d  = StMeasure;
               period_d = div_q;
               high_d   = h_q;
               duty_d   = duty_clamp;
               valid_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (!en) begin
         state_d    = StIdle;
         valid_d    = 1'b0;
         overflow_d = 1'b0;
         missed_d   = 1'b0;
         period_d   = period_q;
         high_d     = high_q;
         duty_d     = duty_q;
      end

      // Registered copy of (state == MEASURE && per_cnt saturated).
      signal_lost_d = (state_d == StMeasure) && (per_cnt_d == CntMax);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         sync_q        <= '0;
         prev_q        <= 1'b0;
         per_cnt_q     <= '0;
         hi_cnt_q      <= '0;
         num_q         <= '0;
         rem_q         <= '0;
         div_q         <= '0;
         h_q           <= '0;
         bit_cnt_q     <= '0;
         period_q      <= '0;
         high_q        <= '0;
         duty_q        <= '0;
         valid_q       <= 1'b0;
         overflow_q    <= 1'b0;
         missed_q      <= 1'b0;
         signal_lost_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync_q        <= sync_d;
         prev_q        <= s;
         per_cnt_q     <= per_cnt_d;
         hi_cnt_q      <= hi_cnt_d;
         num_q         <= num_d;
         rem_q         <= rem_d;
         div_q         <= div_d;
         h_q           <= h_d;
         bit_cnt_q     <= bit_cnt_d;
         period_q      <= period_d;
         high_q        <= high_d;
         duty_q        <= duty_d;
         valid_q       <= valid_d;
         overflow_q    <= overflow_d;
         missed_q      <= missed_d;
         signal_lost_q <= signal_lost_d;
      end
   end

   assign period_out  = period_q;
   assign high_out    = high_q;
   assign duty_pct    = duty_q;
   assign valid       = valid_q;
   assign overflow    = overflow_q;
   assign missed      = missed_q;
   assign signal_lost = signal_lost_q;

   a_ovf_valid: assert property (@(posedge clk) disable iff (!rst_n) overflow |-> valid);
   a_duty_rng:  assert property (@(posedge clk) disable iff (!rst_n) duty_pct <= 7'd100);
   a_lost_st:   assert property (@(posedge clk) disable iff (!rst_n)
                                 signal_lost |-> (state_q == StMeasure));

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM waveforms cycle by cycle and checks results,
// latency, missed pulses, signal loss, enable abort and asynchronous reset.
module tb_pwm_capture;

   localparam int unsigned CNT_W = 12;

   typedef struct {
      int c;
      int per;
      int hi;
      int duty;
      int ovf;
   } ev_t;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             pwm_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic [6:0]       duty_pct;
   logic             valid;
   logic             overflow;
   logic             missed;
   logic             signal_lost;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   ev_t  vq[$];
   int   mq[$];
   int   rq[$];

   pwm_capture #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .pwm_in      (pwm_in),
      .period_out  (period_out),
      .high_out    (high_out),
      .duty_pct    (duty_pct),
      .valid       (valid),
      .overflow    (overflow),
      .missed      (missed),
      .signal_lost (signal_lost)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Event log of valid/missed pulses with the cycle they were seen in.
   always @(negedge clk) begin
      if (rst_n && valid) begin
         vq.push_back('{cyc, int'(period_out), int'(high_out), int'(duty_pct), int'(overflow)});
      end
      if (rst_n && missed) begin
         mq.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_ev(input string tag, input int idx, input int exp_c, input int per,
                           input int hi, input int duty, input int ovf);
      if (idx < vq.size()) begin
         check($sformatf("%s[%0d].cycle", tag, idx), vq[idx].c, exp_c);
         check($sformatf("%s[%0d].period", tag, idx), vq[idx].per, per);
         check($sformatf("%s[%0d].high", tag, idx), vq[idx].hi, hi);
         check($sformatf("%s[%0d].duty", tag, idx), vq[idx].duty, duty);
         check($sformatf("%s[%0d].overflow", tag, idx), vq[idx].ovf, ovf);
      end
   endtask

   task automatic drive_level(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (v && !pwm_in) rq.push_back(cyc);
         pwm_in = v;
      end
   endtask

   task automatic drive_pwm(input int per, input int hi, input int n);
      for (int k = 0; k < n; k++) begin
         drive_level(1'b1, hi);
         drive_level(1'b0, per - hi);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic restart_capture();
      en = 1'b0;
      drive_level(1'b0, 3);
      en = 1'b1;
      vq.delete();
      mq.delete();
      rq.delete();
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", period_out, 0);
      check("rst_high", high_out, 0);
      check("rst_duty", duty_pct, 0);
      check("rst_flags", {valid, overflow, missed, signal_lost}, 0);
      rst_n = 1'b1;

      // 100/25: first edge arms, then one result per period at E+20
      restart_capture();
      drive_pwm(100, 25, 4);
      check("p100_nvalid", vq.size(), 3);
      check("p100_nmissed", mq.size(), 0);
      for (int j = 0; j < 3; j++) check_ev("p100", j, rq[j+1] + 22, 100, 25, 25, 0);

      // 300/100: floor of 33.3
      restart_capture();
      drive_pwm(300, 100, 2);
      check("p300_nvalid", vq.size(), 1);
      check_ev("p300", 0, rq[1] + 22, 300, 100, 33, 0);

      // 7/1: second period closes mid-divide and is dropped
      restart_capture();
      drive_pwm(7, 1, 3);
      drive_level(1'b0, 30);
      check("p7_nvalid", vq.size(), 1);
      check_ev("p7", 0, rq[1] + 22, 7, 1, 14, 0);
      check("p7_nmissed", mq.size(), 1);
      if (mq.size() > 0) check("p7_missed_cyc", mq[0], rq[2] + 3);

      // 10/5: valid and missed alternate
      restart_capture();
      drive_pwm(10, 5, 6);
      drive_level(1'b0, 30);
      check("p10_nvalid", vq.size(), 3);
      for (int j = 0; j < 3; j++) check_ev("p10", j, rq[2*j+1] + 22, 10, 5, 50, 0);
      check("p10_nmissed", mq.size(), 2);
      for (int j = 0; j < 2 && j < mq.size(); j++) begin
         check($sformatf("p10_missed_cyc[%0d]", j), mq[j], rq[2*j+2] + 3);
      end

      // Input stuck low: signal_lost after saturation, then an overflow result
      restart_capture();
      drive_pwm(100, 25, 3);
      check("lost_nvalid", vq.size(), 2);
      wait_until(rq[2] + 4096);
      check("lost_before_sat", signal_lost, 0);
      @(negedge clk);
      check("lost_at_sat", signal_lost, 1);
      wait_until(rq[2] + 5000);
      check("lost_held", signal_lost, 1);
      vq.delete();
      drive_level(1'b1, 25);
      drive_level(1'b0, 10);
      check("ovf_nvalid", vq.size(), 1);
      check_ev("ovf", 0, rq[3] + 3, 4095, 25, 0, 1);
      check("lost_cleared", signal_lost, 0);

      // Drop en mid-divide: no result, outputs hold; re-enable re-arms
      restart_capture();
      drive_pwm(300, 100, 1);
      drive_level(1'b1, 10);
      en = 1'b0;
      drive_level(1'b1, 90);
      drive_level(1'b0, 50);
      check("abort_nvalid", vq.size(), 0);
      check("abort_period_hold", period_out, 4095);
      check("abort_high_hold", high_out, 25);
      check("abort_duty_hold", duty_pct, 0);
      en = 1'b1;
      drive_pwm(300, 100, 2);
      check("reen_nvalid", vq.size(), 1);
      check_ev("reen", 0, rq[3] + 22, 300, 100, 33, 0);

      // Async reset mid-divide
      drive_level(1'b1, 5);
      check("prerst_period", period_out, 300);
      rst_n = 1'b0;
      #1;
      check("arst_period", period_out, 0);
      check("arst_high", high_out, 0);
      check("arst_duty", duty_pct, 0);
      check("arst_flags", {valid, overflow, missed, signal_lost}, 0);
      drive_level(1'b0, 5);
      rst_n = 1'b1;
      vq.delete();
      mq.delete();
      rq.delete();
      drive_level(1'b0, 3);
      drive_pwm(100, 25, 2);
      check("postrst_nvalid", vq.size(), 1);
      check_ev("postrst", 0, rq[1] + 22, 100, 25, 25, 0);
      check("postrst_nmissed", mq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side companion to the team's PWM generator: measures an incoming PWM waveform and reports period (clk cycles), high time (clk cycles) and duty in integer percent (0..100).
- Used for loopback self-test of the generator output and for decoding external PWM inputs.
- Architecture: input synchronizer, edge detector, period/high counters, 3-state FSM, sequential restoring divider.

Parameters:
- CNT_W, 12, width of period/high counters and outputs.
- SYNC_STAGES, 2, flip-flop stages in the pwm_in synchronizer (min 2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  capture enable; low aborts and returns to IDLE.
- pwm_in  input  1  asynchronous PWM input.
- period_out  output  CNT_W  last measured period in clk cycles.
- high_out  output  CNT_W  last measured high time in clk cycles.
- duty_pct  output  7  floor(high*100/period), 0..100.
- valid  output  1  one-cycle pulse; outputs updated this cycle.
- overflow  output  1  qualifies valid: measured period saturated, result unusable.
- missed  output  1  one-cycle pulse: a period completed while the divider was busy; that result is dropped.
- signal_lost  output  1  level: period counter saturated in MEASURE (no rising edge for 2^CNT_W-1 cycles).

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, synchronizer and edge-detect flops 0.
- Sync: pwm_in passes through SYNC_STAGES flops giving s. prev is s delayed by 1. rise = s & ~prev. The cycle where rise=1 is cycle E.
- per_cnt: at E, loads 1. Otherwise increments, saturating at 2^CNT_W-1.
- hi_cnt: at E, loads 1. Otherwise increments while s=1 (saturating), holds while s=0.
  - Example: high for H cycles within period P gives per_cnt=P and hi_cnt=H at the next E.
- Counters run in MEASURE and DIVIDE. Both are held at 0 in IDLE.
- FSM IDLE:
  - en=0: stay.
  - en=1 and rise: load counters and go to MEASURE. The first edge only arms; no result.
- FSM MEASURE, on rise (before counters reload):
  - Latch P=per_cnt and H=hi_cnt.
  - If P saturated: next cycle pulse valid and overflow, period_out=all ones, high_out=H, duty_pct=0, stay MEASURE.
  - Else go to DIVIDE with numerator H*100 (CNT_W+7 bits) and divisor P.
- FSM DIVIDE:
  - Restoring division, 1 quotient bit per cycle, CNT_W+7 cycles (19 at default).
  - On completion: in one cycle, register period_out=P, high_out=H, duty_pct=quotient (saturate at 100), valid=1, overflow=0; return to MEASURE.
  - Latency: valid high in cycle E+CNT_W+8 (E+20 at default).
- rise while in DIVIDE: counters reload normally, the new period is discarded, missed pulses in cycle E+1, and the divide continues unaffected.
- signal_lost: set while state=MEASURE and per_cnt==2^CNT_W-1; cleared on the next rise, on en=0, or on reset.
- en=0 in any state: next cycle IDLE, divide aborted with no valid, counters cleared. period_out, high_out and duty_pct hold their last values.
- Constant-level input produces no rise: no valid, and signal_lost asserts after saturation.
- Divisor is never 0: a rise needs s low for at least 1 cycle, so P≥2 and H≤P-1. Duty therefore never exceeds 99 from real edges; the saturation at 100 is a safety clamp.
- rst_n asserted mid-divide or mid-measure: immediate return to reset values.

Test Plan:
- Period 100, high 25, 3 periods, en=1: first edge arms, no valid; then each period gives valid with period_out=100, high_out=25, duty_pct=25, exactly at E+20.
- Period 300, high 100: duty_pct=33 (floor), high_out=100. Period 7, high 1: duty_pct=14.
- Period 10, high 5 (shorter than divide time): a valid and a missed pulse alternate as periods complete during DIVIDE; reported results are 10/5/50.
- pwm_in held low after 2 good periods: signal_lost=1 after 4095 cycles; next rise (period > 4095) gives valid with overflow=1, period_out=4095, duty_pct=0, and clears signal_lost.
- Drop en mid-DIVIDE: no valid, outputs hold prior values; re-enable: first edge arms only, second gives a correct result.
- Assert rst_n mid-DIVIDE: all outputs 0 immediately (async); after release, capture restarts from IDLE.
